// File: rtl/vc_switch_allocator_pkg.sv
// Shared definitions for the VC router switch allocator: index-width helpers,
// one-hot validity check and the per-output packet-lock entry.
package vc_router_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_NUM_VCS   = 4;
    localparam int IDX_W         = 8;

    // Index widths never drop below 1 so degenerate sizes still elaborate.
    function automatic int port_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int vc_w(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic logic onehot_valid(input logic [63:0] vec);
        return (vec != '0) && ((vec & (vec - 64'd1)) == '0);
    endfunction

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] vc_idx;
        logic [IDX_W-1:0] in_idx;
    } lock_entry_t;

endpackage

// File: rtl/vc_switch_allocator_if.sv
// Request/grant bundle between the input VC buffers and the switch allocator.
interface vc_switch_allocator_if
    import vc_router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_VCS   = DEF_NUM_VCS
);
    // Handshake: a VC holds req_valid/req_port/req_tail steady until granted;
    // grant_* is combinational and the upstream dequeues in the same cycle.
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                req_valid;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][NUM_PORTS-1:0] req_port;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                req_tail;
    logic [NUM_PORTS-1:0]                             out_ready;
    logic [NUM_PORTS-1:0]                             grant_valid;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                grant_vc;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]              grant_port;

    modport master (
        output req_valid, req_port, req_tail, out_ready,
        input  grant_valid, grant_vc, grant_port
    );

    modport slave (
        input  req_valid, req_port, req_tail, out_ready,
        output grant_valid, grant_vc, grant_port
    );
endinterface

// File: rtl/vc_switch_allocator_rr_arbiter.sv
// Stateful round-robin arbiter; the pointer marks the highest-priority index
// and moves past the winner only when the caller confirms a final grant.
module rr_arbiter
    import vc_router_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         update_en,
    output logic [N-1:0] grant
);
    if (N == 1) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, reset, update_en};
        assign grant = req;
    end else begin : g_rr
        localparam int PW = port_w(N);
        logic [PW-1:0] ptr_q;
        logic [PW-1:0] ptr_next;
        logic          found;

        always_comb begin
            grant    = '0;
            found    = 1'b0;
            ptr_next = ptr_q;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(int'(ptr_q) + k) % N]) begin
                    grant[(int'(ptr_q) + k) % N] = 1'b1;
                    found    = 1'b1;
                    ptr_next = PW'((int'(ptr_q) + k + 1) % N);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset)
                ptr_q <= '0;
            else if (update_en && found)
                ptr_q <= ptr_next;
        end
    end
endmodule

// File: rtl/vc_switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then
// per-output input arbitration, with optional head-to-tail output locking.
module vc_switch_allocator
    import vc_router_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int NUM_VCS     = DEF_NUM_VCS,
    parameter bit PACKET_LOCK = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_switch_allocator_if.slave  alloc
);
    localparam int NP = NUM_PORTS;
    localparam int NV = NUM_VCS;

    logic [NP-1:0][NV-1:0] elig, s1_gnt;
    logic [NP-1:0][NP-1:0] s1_port;          // [input][output]
    logic [NP-1:0][NP-1:0] s2_req, s2_gnt;   // [output][input]
    logic [NP-1:0][NP-1:0] gport;            // [input][output]
    logic [NP-1:0]         gvalid, s1_upd, s2_upd;
    logic [NP-1:0]         locked_ports, in_locked;
    logic [NP-1:0][NV-1:0] in_lock_vc;
    logic [NP-1:0][NP-1:0] in_lock_port;

    // A locked input may only present its holder VC toward its locked port;
    // everyone else is kept off locked outputs.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NP; i++) begin
            for (int v = 0; v < NV; v++) begin
                elig[i][v] = alloc.req_valid[i][v]
                    && onehot_valid(64'(alloc.req_port[i][v]))
                    && ((alloc.req_port[i][v] & alloc.out_ready) != '0)
                    && (in_locked[i]
                        ? (in_lock_vc[i][v] && (alloc.req_port[i][v] == in_lock_port[i]))
                        : ((alloc.req_port[i][v] & locked_ports) == '0));
            end
        end
    end

    always_comb begin
        s1_port = '0;
        s2_req  = '0;
        gport   = '0;
        gvalid  = '0;
        s1_upd  = '0;
        s2_upd  = '0;
        for (int i = 0; i < NP; i++)
            for (int v = 0; v < NV; v++)
                if (s1_gnt[i][v])
                    s1_port[i] = s1_port[i] | alloc.req_port[i][v];
        for (int o = 0; o < NP; o++)
            for (int i = 0; i < NP; i++) begin
                s2_req[o][i] = s1_port[i][o];
                gport[i][o]  = s2_gnt[o][i];
            end
        for (int i = 0; i < NP; i++) begin
            gvalid[i] = |gport[i];
            s1_upd[i] = gvalid[i] && !in_locked[i];
        end
        for (int o = 0; o < NP; o++)
            s2_upd[o] = (|s2_gnt[o]) && !locked_ports[o];
    end

    for (genvar g = 0; g < NP; g++) begin : g_arb
        rr_arbiter #(.N(NV)) u_s1 (
            .clk(clk), .reset(reset), .req(elig[g]),
            .update_en(s1_upd[g]), .grant(s1_gnt[g])
        );
        rr_arbiter #(.N(NP)) u_s2 (
            .clk(clk), .reset(reset), .req(s2_req[g]),
            .update_en(s2_upd[g]), .grant(s2_gnt[g])
        );
    end

    always_comb begin
        alloc.grant_valid = '0;
        alloc.grant_vc    = '0;
        alloc.grant_port  = '0;
        if (!reset) begin
            alloc.grant_valid = gvalid;
            alloc.grant_port  = gport;
            for (int i = 0; i < NP; i++)
                if (gvalid[i])
                    alloc.grant_vc[i] = s1_gnt[i];
        end
    end

    if (PACKET_LOCK) begin : g_lock
        lock_entry_t            lock_q [NP];
        logic [NP-1:0]          win_any, win_tail;
        logic [NP-1:0][IDX_W-1:0] win_in, win_vc;

        always_comb begin
            locked_ports = '0;
            in_locked    = '0;
            in_lock_vc   = '0;
            in_lock_port = '0;
            for (int o = 0; o < NP; o++)
                if (lock_q[o].valid) begin
                    locked_ports[o] = 1'b1;
                    for (int i = 0; i < NP; i++)
                        if (lock_q[o].in_idx == IDX_W'(i)) begin
                            in_locked[i]       = 1'b1;
                            in_lock_port[i][o] = 1'b1;
                            for (int v = 0; v < NV; v++)
                                if (lock_q[o].vc_idx == IDX_W'(v))
                                    in_lock_vc[i][v] = 1'b1;
                        end
                end
        end

        always_comb begin
            win_any  = '0;
            win_tail = '0;
            win_in   = '0;
            win_vc   = '0;
            for (int o = 0; o < NP; o++) begin
                win_any[o] = |s2_gnt[o];
                for (int i = 0; i < NP; i++)
                    for (int v = 0; v < NV; v++)
                        if (gport[i][o] && s1_gnt[i][v]) begin
                            win_tail[o] = alloc.req_tail[i][v];
                            win_in[o]   = IDX_W'(i);
                            win_vc[o]   = IDX_W'(v);
                        end
            end
        end

        // While locked, the only possible winner on an output is the holder.
        always_ff @(posedge clk) begin
            for (int o = 0; o < NP; o++) begin
                if (reset)
                    lock_q[o] <= '0;
                else if (lock_q[o].valid) begin
                    if (win_any[o] && win_tail[o])
                        lock_q[o] <= '0;
                end else if (win_any[o] && !win_tail[o])
                    lock_q[o] <= '{valid: 1'b1, vc_idx: win_vc[o], in_idx: win_in[o]};
            end
        end
    end else begin : g_nolock
        logic unused_tail;
        assign unused_tail  = ^alloc.req_tail;
        assign locked_ports = '0;
        assign in_locked    = '0;
        assign in_lock_vc   = '0;
        assign in_lock_port = '0;
    end
endmodule

// File: tb/tb_vc_switch_allocator.sv
// Directed bench for vc_switch_allocator: one per-flit instance and one
// packet-lock instance, checked cycle by cycle against an expected queue.
module tb_vc_switch_allocator;
    localparam int NP = 4;
    localparam int NV = 4;
    localparam int W  = NP + NP * NV + NP * NP;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vc_switch_allocator_if #(.NUM_PORTS(NP), .NUM_VCS(NV)) if0 ();
    vc_switch_allocator_if #(.NUM_PORTS(NP), .NUM_VCS(NV)) if1 ();

    vc_switch_allocator #(.NUM_PORTS(NP), .NUM_VCS(NV), .PACKET_LOCK(1'b0)) dut0 (
        .clk(clk), .reset(reset), .alloc(if0)
    );
    vc_switch_allocator #(.NUM_PORTS(NP), .NUM_VCS(NV), .PACKET_LOCK(1'b1)) dut1 (
        .clk(clk), .reset(reset), .alloc(if1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [NP-1:0]         exp_gv;
    logic [NP-1:0][NV-1:0] exp_vc;
    logic [NP-1:0][NP-1:0] exp_port;
    bit sel;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {gv,vc,port}=%h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        if0.req_valid = '0; if0.req_port = '0; if0.req_tail = '0; if0.out_ready = '1;
        if1.req_valid = '0; if1.req_port = '0; if1.req_tail = '0; if1.out_ready = '1;
    endtask

    task automatic set_req(input bit d, input int i, input int v, input int o, input bit tail);
        if (!d) begin
            if0.req_valid[i][v] = 1'b1; if0.req_port[i][v] = '0;
            if0.req_port[i][v][o] = 1'b1; if0.req_tail[i][v] = tail;
        end else begin
            if1.req_valid[i][v] = 1'b1; if1.req_port[i][v] = '0;
            if1.req_port[i][v][o] = 1'b1; if1.req_tail[i][v] = tail;
        end
    endtask

    task automatic expect_none();
        exp_gv = '0; exp_vc = '0; exp_port = '0;
    endtask

    task automatic expect_grant(input int i, input int v, input int o);
        exp_gv[i] = 1'b1; exp_vc[i][v] = 1'b1; exp_port[i][o] = 1'b1;
    endtask

    // Called just after a negedge with inputs settled; returns at the next negedge.
    task automatic cycle(input string tag);
        logic [W-1:0] obs, e;
        exp_q.push_back({exp_gv, exp_vc, exp_port});
        #2;
        obs = sel ? {if1.grant_valid, if1.grant_vc, if1.grant_port}
                  : {if0.grant_valid, if0.grant_vc, if0.grant_port};
        e = exp_q.pop_front();
        check_eq(tag, obs, e);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        expect_none();
        cycle(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        clear_reqs();
        @(negedge clk);

        // Outputs forced low while reset is high, even with live requests.
        set_req(0, 1, 2, 3, 1'b1);
        set_req(1, 1, 2, 3, 1'b1);
        expect_none();
        cycle("reset_out_nolock");
        sel = 1'b1;
        cycle("reset_out_lock");
        reset = 1'b0;
        sel   = 1'b0;

        // Single request, same-cycle grant.
        clear_reqs();
        set_req(0, 1, 2, 3, 1'b1);
        expect_none(); expect_grant(1, 2, 3);
        cycle("single");

        // Output fairness: inputs 0..2 all on port 0.
        clear_reqs();
        for (int i = 0; i < 3; i++) set_req(0, i, 0, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            expect_none(); expect_grant(k % 3, 0, 0);
            cycle($sformatf("out_fair_%0d", k));
        end

        // VC fairness with one blocked cycle first.
        do_reset("reset_vc_fair");
        clear_reqs();
        set_req(0, 0, 0, 1, 1'b1);
        set_req(0, 0, 3, 1, 1'b1);
        if0.out_ready = 4'b1101;
        expect_none();
        cycle("vc_fair_blocked");
        if0.out_ready = '1;
        for (int k = 0; k < 4; k++) begin
            expect_none(); expect_grant(0, (k % 2 == 0) ? 0 : 3, 1);
            cycle($sformatf("vc_fair_%0d", k));
        end

        // Malformed requests: move input 2 pointer to VC 2, then show it is kept.
        do_reset("reset_malformed");
        clear_reqs();
        set_req(0, 2, 1, 0, 1'b1);
        expect_none(); expect_grant(2, 1, 0);
        cycle("mal_setup");
        clear_reqs();
        if0.req_valid[2][3] = 1'b1; if0.req_port[2][3] = 4'b0110;
        expect_none();
        cycle("mal_multihot");
        if0.req_port[2][3] = 4'b0000;
        cycle("mal_zerohot");
        clear_reqs();
        set_req(0, 2, 0, 1, 1'b1);
        set_req(0, 2, 2, 1, 1'b1);
        expect_none(); expect_grant(2, 2, 1);
        cycle("mal_ptr_kept");

        // Parallel grants to distinct outputs, one conflict on port 2.
        clear_reqs();
        set_req(0, 0, 0, 1, 1'b1);
        set_req(0, 1, 0, 2, 1'b1);
        set_req(0, 2, 0, 2, 1'b1);
        set_req(0, 3, 0, 3, 1'b1);
        expect_none(); expect_grant(0, 0, 1); expect_grant(1, 0, 2); expect_grant(3, 0, 3);
        cycle("parallel");

        // Packet lock on port 2 held by (0,1).
        sel = 1'b1;
        do_reset("reset_lock");
        clear_reqs();
        set_req(1, 0, 1, 2, 1'b0);
        set_req(1, 3, 0, 2, 1'b1);
        expect_none(); expect_grant(0, 1, 2);
        cycle("lock_head");
        set_req(1, 0, 3, 0, 1'b1);
        expect_none(); expect_grant(0, 1, 2);
        cycle("lock_body");
        if1.req_valid[0][1] = 1'b0;
        expect_none();
        cycle("lock_bubble");
        if1.req_valid[0][1] = 1'b1;
        if1.out_ready[2] = 1'b0;
        expect_none();
        cycle("lock_not_ready");
        if1.out_ready = '1;
        set_req(1, 0, 1, 2, 1'b1);
        expect_none(); expect_grant(0, 1, 2);
        cycle("lock_tail");
        if1.req_valid[0][1] = 1'b0;
        expect_none(); expect_grant(3, 0, 2); expect_grant(0, 3, 0);
        cycle("lock_released");

        // Reset while a lock is held.
        do_reset("reset_rml");
        clear_reqs();
        set_req(1, 0, 1, 2, 1'b0);
        set_req(1, 3, 0, 2, 1'b1);
        expect_none(); expect_grant(0, 1, 2);
        cycle("rml_head");
        reset = 1'b1;
        expect_none();
        cycle("rml_reset_out");
        reset = 1'b0;
        if1.req_valid[0][1] = 1'b0;
        expect_none(); expect_grant(3, 0, 2);
        cycle("rml_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
